clock_mux_ctrl: RTL

CLOCK_MUX_CTRL -- requirements
Module: clock_mux_ctrl

---
 rtl/clock_mux_ctrl_pkg.sv | 26 ++
 rtl/clock_mux_ctrl_timer.sv | 34 +++
 rtl/clock_mux_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clock_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_mux_ctrl_pkg
// Description : Shared state encoding and default timing for clock_mux_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_mux_ctrl_pkg;

    localparam int unsigned c_def_gate_off_cycles = 4;
    localparam int unsigned c_def_settle_cycles   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SWITCH = 3'd2,
        SETTLE = 3'd3,
        RESUME = 3'd4
    } state_t;

    // A phase of N cycles (minimum one) counts down from N-1 to zero.
    function automatic int unsigned load_count(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_mux_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : clock_mux_ctrl_timer
// Description : Loadable down-counter with zero flag; holds at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_mux_ctrl_timer #(
    parameter int unsigned          W       = 8,
    parameter logic [W-1:0]         RST_VAL = '0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_load,
    input  wire logic [W-1:0]       i_load_val,
    input  wire logic               i_dec,
    output logic                    o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !o_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/clock_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_mux_ctrl
// Description : Glitch-free clock-mux select sequencer (drain/switch/settle).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_mux_ctrl
    import clock_mux_ctrl_pkg::*;
#(
    parameter int unsigned GATE_OFF_CYCLES = c_def_gate_off_cycles,
    parameter int unsigned SETTLE_CYCLES   = c_def_settle_cycles,
    parameter int unsigned CNT_W           = 8
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic REQ_SELECT,
    input  wire logic REQ_VALID,
    output logic      REQ_READY,
    output logic      SELECT,
    output logic      SELECT_ENABLE,
    output logic      GATE_EN,
    output logic      CUR_SEL,
    output logic      BUSY,
    output logic      DONE
);

    localparam logic [CNT_W-1:0] c_drain_load  = CNT_W'(load_count(GATE_OFF_CYCLES));
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(load_count(SETTLE_CYCLES));

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_target;
    logic               w_target_nxt;
    logic               r_cur_sel;
    logic               r_pend_valid;
    logic               r_pend_sel;
    logic               r_done_same;
    logic               w_done_same_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_disp_valid;
    logic               w_disp_sel;
    logic               w_tmr_load;
    logic [CNT_W-1:0]   w_tmr_val;
    logic               w_tmr_dec;
    logic               w_tmr_zero;

    assign w_ready  = !r_pend_valid;
    assign w_accept = REQ_VALID && w_ready && !RST;

    // In IDLE a stored request takes priority; the port is not ready then anyway.
    assign w_disp_valid = r_pend_valid || w_accept;
    assign w_disp_sel   = r_pend_valid ? r_pend_sel : REQ_SELECT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= DRAIN;
            r_target     <= 1'b0;
            r_cur_sel    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_done_same  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_done_same <= w_done_same_nxt;
            if (r_state == SWITCH) begin
                r_cur_sel <= r_target;
            end
            if (r_state == IDLE) begin
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= REQ_SELECT;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_done_same_nxt = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_val       = c_drain_load;
        w_tmr_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_disp_valid) begin
                    if (w_disp_sel != r_cur_sel) begin
                        w_target_nxt = w_disp_sel;
                        w_state_nxt  = DRAIN;
                        w_tmr_load   = 1'b1;
                    end else begin
                        w_done_same_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_tmr_zero) begin
                    w_state_nxt = SWITCH;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            SWITCH: begin
                w_state_nxt = SETTLE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_settle_load;
            end
            SETTLE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = RESUME;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            RESUME: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = DRAIN;
                w_tmr_load  = 1'b1;
            end
        endcase
    end

    clock_mux_ctrl_timer #(
        .W       (CNT_W),
        .RST_VAL (c_drain_load)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Outputs are forced to their reset values while RST is high, including its first cycle.
    assign REQ_READY     = RST || w_ready;
    assign SELECT_ENABLE = !RST && (r_state == SWITCH);
    assign SELECT        = RST ? 1'b0 : ((r_state == SWITCH) ? r_target : r_cur_sel);
    assign GATE_EN       = !RST && ((r_state == IDLE) || (r_state == RESUME));
    assign CUR_SEL       = RST ? 1'b0 : r_cur_sel;
    assign BUSY          = RST || (r_state != IDLE);
    assign DONE          = !RST && ((r_state == RESUME) || r_done_same);

endmodule
`default_nettype wire
